mips_fetch_stage: RTL and testbench
===================================

Name: mips_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS core. It sits directly upstream of main decode and supplies the instruction word whose [31:26] field becomes decode's Op.
- Owns the PC and issues word reads to instruction memory over a grant/response handshake.
- Buffers returned words in a small FIFO and presents them to decode with valid/ready.
- Redirects on taken branch (from execute) or on decode's Jump.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IReq  out  1  memory read request.
- IAddr  out  32  request word address (PC).
- IGnt  in  1  memory accepts the request this cycle.
- IRspValid  in  1  read data valid; arrives ≥1 cycle after grant.
- IRspData  in  32  read data.
- InstrValid  out  1  buffer head valid.
- Instr  out  32  head instruction.
- InstrPc  out  32  head PC.
- PcPlus4  out  32  InstrPc+4.
- DecReady  in  1  decode consumes head when InstrValid&DecReady.
- BranchTaken  in  1  redirect to BranchTarget.
- BranchTarget  in  32  branch target.
- Jump  in  1  decode's Jump for the head instruction.
- JumpIndex  in  26  head Instr[25:0].

Behaviour:
- Reset (async, rst_n=0):
  - Pc=RESET_PC; FSM=IDLE; buffer empty; Kill=0.
  - Outputs: IReq=0, IAddr=RESET_PC, InstrValid=0, Instr=0, InstrPc=0, PcPlus4=4.
  - Reset mid-transaction discards any outstanding response; a response arriving in IDLE is ignored.
- FSM IDLE: one cycle after reset release, then REQ.
- FSM REQ:
  - IReq=1 iff (count + outstanding) < DEPTH; IAddr=Pc.
  - On IReq&IGnt: ReqPc<=Pc, Pc<=Pc+4 (mod 2^32, wraps), go WAIT.
- FSM WAIT:
  - IReq=0.
  - On IRspValid: if Kill, drop the data and clear Kill; else push {IRspData, ReqPc}. Go REQ.
  - Push and pop in the same cycle are legal with count unchanged. Push never occurs when full; the request rule guarantees this.
- Throughput: one instruction per 2 cycles with single-cycle memory; max one outstanding request.
- Head: InstrValid=(count≠0); Instr/InstrPc from head entry; PcPlus4=InstrPc+4. Head values are held stable while InstrValid&!DecReady.
- Redirect:
  - Redirect = BranchTaken | (Jump & InstrValid).
  - Target priority: branch over jump (branch is older).
  - Jump target = {PcPlus4[31:28], JumpIndex, 2'b00}.
  - Effect, next edge: Pc<=target; buffer flushed, so InstrValid=0 the next cycle; any pop that cycle is cancelled.
  - If a request is outstanding, or is granted in the redirect cycle, Kill<=1 and the next response is dropped.
  - FSM goes to WAIT if a request is outstanding or just granted, else REQ.
  - A response arriving in the redirect cycle is dropped and is not pushed.
  - First post-redirect IReq: IAddr=target, at the earliest the cycle after the redirect (or after the killed response).
- No delay slot: instructions after the branch/jump are discarded.

Optional Feature:
- Macro: MIPS_FETCH_MISALIGN_EN.
- Defined:
  - Extra output FetchMisalign (1b, reset 0). It pulses for one cycle when a redirect target has [1:0]≠0.
  - Pc is loaded with target & ~32'h3.
- Undefined:
  - Port is absent; target is loaded unmodified.
  - IAddr may be misaligned; behaviour is the memory's.

Decomposition:
- Package mips_fetch_pkg holds:
  - state enum {IDLE, REQ, WAIT};
  - INSTR_W=32, ADDR_W=32;
  - entry struct {instr, pc};
  - jump-target function.
- One sub-module, mips_fetch_buf: synchronous FIFO of entries with push/pop/flush/count. Flush has priority over push and pop.

Test Plan:
- Reset with RESET_PC=32'hBFC0_0000, IGnt tied 1, 1-cycle memory → IAddr sequence BFC00000, BFC00004, BFC00008; InstrValid rises at cycle 3 with matching InstrPc; one instruction every 2 cycles.
- DecReady=0 for 10 cycles → exactly DEPTH entries buffered, IReq drops to 0, head stable; DecReady=1 → entries drain in order, fetch resumes.
- BranchTaken, BranchTarget=32'h0000_0100, while a request is outstanding → stale response dropped, InstrValid=0 next cycle, next IAddr=100, first delivered InstrPc=100.
- Head PC=32'h1000_0040, Jump=1, JumpIndex=26'h000_0010 → next IAddr=32'h1000_0040; same cycle with BranchTaken to 32'h200 → next IAddr=200.
- Response coincident with redirect, and grant coincident with redirect → both responses dropped; no stale InstrPc ever visible.
- rst_n pulsed low while in WAIT → outputs reset immediately; late IRspValid ignored; fetch restarts at RESET_PC. With MIPS_FETCH_MISALIGN_EN defined: branch to 32'h103 → FetchMisalign pulses, IAddr=32'h100.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and helpers for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // J-type target: upper nibble of the delay-slot PC, 26-bit index, word aligned.
  function automatic logic [ADDR_W-1:0] jump_target(input logic [ADDR_W-1:0] pc_plus4,
                                                    input logic [25:0]       index);
    return {pc_plus4[ADDR_W-1:ADDR_W-4], index, 2'b00};
  endfunction

endpackage

// File: rtl/mips_fetch_buf.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush beats push and pop.
module mips_fetch_buf
  import mips_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && (count != FULL_COUNT);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding memory request, buffered handoff to decode.
// Optional MIPS_FETCH_MISALIGN_EN adds FetchMisalign and word-aligns redirect targets.
module mips_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IGnt,
  input  logic        IRspValid,
  input  logic [31:0] IRspData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPc,
  output logic [31:0] PcPlus4,
  input  logic        DecReady,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex
`ifdef MIPS_FETCH_MISALIGN_EN
  ,
  output logic        FetchMisalign
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_e  state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          kill;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  rsp_entry;
  logic          redirect;
  logic          granted;
  logic          push;
  logic          pop;
  logic [31:0]   target;
  logic [31:0]   load_pc;

  assign InstrValid = (count != '0);
  assign Instr      = InstrValid ? head.instr : '0;
  assign InstrPc    = InstrValid ? head.pc : '0;
  assign PcPlus4    = InstrPc + 32'd4;

  // Nothing is outstanding while in REQ, so only buffer occupancy gates the request.
  assign IReq    = (state == REQ) && (count < FULL_COUNT);
  assign IAddr   = pc;
  assign granted = IReq && IGnt;

  assign redirect = BranchTaken || (Jump && InstrValid);
  assign target   = BranchTaken ? BranchTarget : jump_target(PcPlus4, JumpIndex);

`ifdef MIPS_FETCH_MISALIGN_EN
  assign load_pc = target & ~32'h3;
`else
  assign load_pc = target;
`endif

  assign push      = (state == WAIT) && IRspValid && !kill && !redirect;
  assign pop       = InstrValid && DecReady && !redirect;
  assign rsp_entry = '{instr: IRspData, pc: req_pc};

  mips_fetch_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(rsp_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  // A redirect with a request in flight arms kill so its response is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      kill   <= 1'b0;
    end else if (redirect) begin
      pc <= load_pc;
      if (granted || ((state == WAIT) && !IRspValid)) begin
        kill  <= 1'b1;
        state <= WAIT;
      end else begin
        kill  <= 1'b0;
        state <= REQ;
      end
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (granted) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (IRspValid) begin
            kill  <= 1'b0;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIPS_FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) FetchMisalign <= 1'b0;
    else        FetchMisalign <= redirect && (target[1:0] != 2'b00);
  end
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for mips_fetch_stage with a variable-latency instruction memory model.
module tb_mips_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          DEPTH    = 2;

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b0;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IGnt         = 1'b1;
  logic        IRspValid    = 1'b0;
  logic [31:0] IRspData     = '0;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPc;
  logic [31:0] PcPlus4;
  logic        DecReady     = 1'b1;
  logic        BranchTaken  = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic        Jump         = 1'b0;
  logic [25:0] JumpIndex    = '0;
`ifdef MIPS_FETCH_MISALIGN_EN
  logic        FetchMisalign;
  logic        mis_exp = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cyc    = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  pend_t       pend_q[$];
  exp_t        sb_q[$];
  logic [31:0] exp_addr  = RESET_PC;
  logic        flush_chk = 1'b0;

  mips_fetch_stage #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IReq        (IReq),
    .IAddr       (IAddr),
    .IGnt        (IGnt),
    .IRspValid   (IRspValid),
    .IRspData    (IRspData),
    .InstrValid  (InstrValid),
    .Instr       (Instr),
    .InstrPc     (InstrPc),
    .PcPlus4     (PcPlus4),
    .DecReady    (DecReady),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .Jump        (Jump),
    .JumpIndex   (JumpIndex)
`ifdef MIPS_FETCH_MISALIGN_EN
    ,
    .FetchMisalign(FetchMisalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle and hold these redirect inputs for it.
  task automatic applyStimulus(input logic br, input logic [31:0] tgt,
                               input logic jmp, input logic [25:0] jidx);
    @(posedge clk);
    #1;
    BranchTaken  = br;
    BranchTarget = tgt;
    Jump         = jmp;
    JumpIndex    = jidx;
  endtask

  task automatic waitGrant(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (IReq && IGnt) found = 1'b1;
    end
    checkOutput(tag, found, 1'b1);
  endtask

  task automatic waitValid(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (InstrValid) found = 1'b1;
    end
    checkOutput(tag, found, 1'b1);
  endtask

  // Memory: grants seen mid-cycle, data returned in order after lat cycles.
  always @(negedge clk) begin
    if (IReq && IGnt) pend_q.push_back('{IAddr, cyc + lat});
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    IRspValid = 1'b0;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      IRspValid = 1'b1;
      IRspData  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
  end

  // Scoreboard: expectations queued at grant, retired when decode consumes the head.
  always @(negedge clk) begin : monitor
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] hp4;
    if (!rst_n) begin
      sb_q.delete();
      exp_addr  = RESET_PC;
      flush_chk = 1'b0;
`ifdef MIPS_FETCH_MISALIGN_EN
      mis_exp = 1'b0;
`endif
    end else begin
      redir = BranchTaken || Jump;
`ifdef MIPS_FETCH_MISALIGN_EN
      checkOutput("misalign", FetchMisalign, mis_exp);
      mis_exp = 1'b0;
`endif
      if (flush_chk) checkOutput("flush_valid", InstrValid, 1'b0);
      if (InstrValid) begin
        checkOutput("sb_has_head", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          checkOutput("head_pc", InstrPc, sb_q[0].pc);
          checkOutput("head_instr", Instr, sb_q[0].instr);
          checkOutput("pc_plus4", PcPlus4, sb_q[0].pc + 32'd4);
          if (DecReady && !redir) void'(sb_q.pop_front());
        end
      end
      if (IReq && IGnt) checkOutput("iaddr", IAddr, exp_addr);
      if (redir) begin
        hp4 = (sb_q.size() != 0) ? sb_q[0].pc + 32'd4 : 32'd4;
        tgt = BranchTaken ? BranchTarget : {hp4[31:28], JumpIndex, 2'b00};
`ifdef MIPS_FETCH_MISALIGN_EN
        mis_exp = (tgt[1:0] != 2'b00);
        tgt     = tgt & ~32'h3;
`endif
        exp_addr  = tgt;
        sb_q.delete();
        flush_chk = 1'b1;
      end else begin
        flush_chk = 1'b0;
        if (IReq && IGnt) begin
          sb_q.push_back('{mem_word(exp_addr), exp_addr});
          exp_addr = exp_addr + 32'd4;
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] rnd_tgt;
    logic        rnd_br;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ireq", IReq, 1'b0);
    checkOutput("rst_iaddr", IAddr, RESET_PC);
    checkOutput("rst_valid", InstrValid, 1'b0);
    checkOutput("rst_instr", Instr, 32'h0);
    checkOutput("rst_instrpc", InstrPc, 32'h0);
    checkOutput("rst_pcplus4", PcPlus4, 32'h4);

    $display("[TB] boot fetch from reset vector");
    rst_n = 1'b1;
    checkOutput("c0_idle_ireq", IReq, 1'b0);
    applyStimulus(0, '0, 0, '0);
    checkOutput("c1_ireq", IReq, 1'b1);
    checkOutput("c1_iaddr", IAddr, 32'hBFC0_0000);
    applyStimulus(0, '0, 0, '0);
    checkOutput("c2_valid", InstrValid, 1'b0);
    applyStimulus(0, '0, 0, '0);
    checkOutput("c3_valid", InstrValid, 1'b1);
    checkOutput("c3_pc", InstrPc, 32'hBFC0_0000);
    checkOutput("c3_iaddr", IAddr, 32'hBFC0_0004);
    applyStimulus(0, '0, 0, '0);
    checkOutput("c4_valid", InstrValid, 1'b0);
    applyStimulus(0, '0, 0, '0);
    checkOutput("c5_pc", InstrPc, 32'hBFC0_0004);

    $display("[TB] decode stall");
    DecReady = 1'b0;
    repeat (10) applyStimulus(0, '0, 0, '0);
    checkOutput("stall_valid", InstrValid, 1'b1);
    checkOutput("stall_head", InstrPc, 32'hBFC0_0004);
    checkOutput("stall_ireq", IReq, 1'b0);
    DecReady = 1'b1;
    applyStimulus(0, '0, 0, '0);
    checkOutput("drain_valid", InstrValid, 1'b1);
    checkOutput("drain_pc", InstrPc, 32'hBFC0_0008);
    checkOutput("drain_ireq", IReq, 1'b1);
    checkOutput("drain_iaddr", IAddr, 32'hBFC0_000C);

    $display("[TB] branch with request outstanding");
    lat = 3;
    waitGrant("tmo_grant_br");
    applyStimulus(1, 32'h0000_0100, 0, '0);
    applyStimulus(0, '0, 0, '0);
    checkOutput("br_next_valid", InstrValid, 1'b0);
    checkOutput("br_next_ireq", IReq, 1'b0);
    waitValid("tmo_valid_br");
    checkOutput("br_first_pc", InstrPc, 32'h0000_0100);
    lat = 1;

    $display("[TB] jump and branch-over-jump");
    applyStimulus(1, 32'h1000_0040, 0, '0);
    DecReady = 1'b0;
    applyStimulus(0, '0, 0, '0);
    waitValid("tmo_valid_j1");
    checkOutput("jmp_head_pc", InstrPc, 32'h1000_0040);
    applyStimulus(0, '0, 1, 26'h000_0010);
    applyStimulus(0, '0, 0, '0);
    checkOutput("jmp_flush", InstrValid, 1'b0);
    waitGrant("tmo_grant_j1");
    checkOutput("jmp_iaddr", IAddr, 32'h1000_0040);
    waitValid("tmo_valid_j2");
    checkOutput("jmp_head_pc2", InstrPc, 32'h1000_0040);
    applyStimulus(1, 32'h0000_0200, 1, 26'h000_0010);
    applyStimulus(0, '0, 0, '0);
    DecReady = 1'b1;
    waitGrant("tmo_grant_j2");
    checkOutput("br_over_jmp", IAddr, 32'h0000_0200);

    $display("[TB] redirect coincident with response and grant");
    waitGrant("tmo_grant_co");
    applyStimulus(1, 32'h0000_0300, 0, '0);
    applyStimulus(1, 32'h0000_0400, 0, '0);
    checkOutput("co_ireq", IReq, 1'b1);
    checkOutput("co_iaddr300", IAddr, 32'h0000_0300);
    checkOutput("co_valid_a", InstrValid, 1'b0);
    applyStimulus(0, '0, 0, '0);
    checkOutput("co_valid_b", InstrValid, 1'b0);
    applyStimulus(0, '0, 0, '0);
    checkOutput("co_valid_c", InstrValid, 1'b0);
    checkOutput("co_iaddr400", IAddr, 32'h0000_0400);
    waitValid("tmo_valid_co");
    checkOutput("co_first_pc", InstrPc, 32'h0000_0400);

    $display("[TB] reset while waiting for memory");
    lat = 2;
    waitGrant("tmo_grant_rst");
    applyStimulus(0, '0, 0, '0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ireq", IReq, 1'b0);
    checkOutput("mid_rst_iaddr", IAddr, RESET_PC);
    checkOutput("mid_rst_valid", InstrValid, 1'b0);
    applyStimulus(0, '0, 0, '0);
    rst_n = 1'b1;
    checkOutput("post_rst_idle", IReq, 1'b0);
    applyStimulus(0, '0, 0, '0);
    checkOutput("late_rsp_ignored", InstrValid, 1'b0);
    checkOutput("restart_iaddr", IAddr, RESET_PC);
    waitValid("tmo_valid_rst");
    checkOutput("restart_pc", InstrPc, RESET_PC);
    lat = 1;

`ifdef MIPS_FETCH_MISALIGN_EN
    $display("[TB] misaligned branch target");
    applyStimulus(1, 32'h0000_0103, 0, '0);
    applyStimulus(0, '0, 0, '0);
    checkOutput("mis_pulse", FetchMisalign, 1'b1);
    applyStimulus(0, '0, 0, '0);
    checkOutput("mis_clear", FetchMisalign, 1'b0);
    waitGrant("tmo_grant_mis");
    checkOutput("mis_iaddr", IAddr, 32'h0000_0100);
`endif

    $display("[TB] random stall, latency and branches");
    for (int i = 0; i < 80; i++) begin
      rnd_br  = ($urandom_range(0, 9) == 0);
      rnd_tgt = 32'($urandom_range(0, 1023)) << 2;
      applyStimulus(rnd_br, rnd_tgt, 0, '0);
      DecReady = 1'($urandom_range(0, 1));
      lat      = $urandom_range(1, 3);
    end
    DecReady = 1'b1;
    repeat (20) applyStimulus(0, '0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
